// File: rtl/alu_seq_unit_if.sv
// ============================================================================
// Module   : alu_seq_unit_if
// Purpose  : Operand/result handshake bundle for the sequential ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_seq_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        zero;

    modport slave (
        input  in_valid, op, in0, in1, out_ready,
        output in_ready, out_valid, out, zero
    );

    modport master (
        output in_valid, op, in0, in1, out_ready,
        input  in_ready, out_valid, out, zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq_unit.sv
// ============================================================================
// Module   : alu_seq_unit
// Purpose  : 32-bit RV-style ALU; shifts iterate one bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq_unit (
    input  wire logic      clk,
    input  wire logic      rst_n,
    alu_seq_unit_if.slave  bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_shreg;
    logic [31:0] w_shreg_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [3:0]  r_op;
    logic [3:0]  w_op_nxt;
    logic [31:0] w_alu;
    logic [31:0] w_shift_step;
    logic        w_is_shift;
    logic [4:0]  w_shamt;

    assign w_shamt    = bus.in1[4:0];
    assign w_is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);

    // Single-cycle result; a zero-distance shift simply passes in0 through.
    always_comb begin
        w_alu = 32'd0;
        case (bus.op)
            OP_ADD:  w_alu = bus.in0 + bus.in1;
            OP_SUB:  w_alu = bus.in0 - bus.in1;
            OP_SLT:  w_alu = {31'd0, $signed(bus.in0) < $signed(bus.in1)};
            OP_SLTU: w_alu = {31'd0, bus.in0 < bus.in1};
            OP_XOR:  w_alu = bus.in0 ^ bus.in1;
            OP_OR:   w_alu = bus.in0 | bus.in1;
            OP_AND:  w_alu = bus.in0 & bus.in1;
            OP_SLL, OP_SRL, OP_SRA: w_alu = bus.in0;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_shift_step = {r_shreg[31], r_shreg[31:1]};
        case (r_op)
            OP_SLL:  w_shift_step = {r_shreg[30:0], 1'b0};
            OP_SRL:  w_shift_step = {1'b0, r_shreg[31:1]};
            default: w_shift_step = {r_shreg[31], r_shreg[31:1]};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_op_nxt = bus.op;
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        w_state_nxt = SHIFT;
                        w_shreg_nxt = bus.in0;
                        w_cnt_nxt   = w_shamt;
                    end else begin
                        w_state_nxt = DONE;
                        w_shreg_nxt = w_alu;
                        w_cnt_nxt   = 5'd0;
                    end
                end
            end
            SHIFT: begin
                w_shreg_nxt = w_shift_step;
                w_cnt_nxt   = r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                    w_shreg_nxt = 32'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_shreg_nxt = 32'd0;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= 32'd0;
            r_cnt   <= 5'd0;
            r_op    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // The result register doubles as the shifter, so it is masked until DONE.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out       = (r_state == DONE) ? r_shreg : 32'd0;
    assign bus.zero      = (r_state == DONE) && (r_shreg == 32'd0);

endmodule

`default_nettype wire
